// File: rtl/serial_interface_param.sv
// Parametrised UART-style serial interface: words from the core are queued, sent
// as LSB-first byte frames with optional parity, and reassembled on the receive side.
module serial_interface_param #(
   parameter int DATA_W       = 32,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY       = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              control,
   input  logic              rd_en,
   input  logic              rx,
   output logic              tx,
   output logic [DATA_W-1:0] data_out,
   output logic              tx_full,
   output logic              tx_busy,
   output logic              rx_empty,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   input  logic              clr_err
);
   localparam int BYTES = DATA_W / 8;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PW    = AW + 1;
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
   localparam bit HAS_PAR = (PARITY != 0);
   localparam bit ODD_PAR = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   // Reset asserts immediately but is released only on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // ---------------------------------------------------------------- TX FIFO
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [PW-1:0]     tx_wr_ptr, tx_rd_ptr;
   logic              tx_empty, tx_push, tx_pop;

   assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
   assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                     (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
   assign tx_push  = control && !tx_full;

   // NOTE: storage arrays are not reset; the pointers alone decide which entries
   // are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      end
   end

   // ---------------------------------------------------------------- TX FSM
   state_t            tx_state, tx_state_n;
   logic [CW-1:0]     tx_cnt, tx_cnt_n;
   logic [2:0]        tx_bit, tx_bit_n;
   logic [BW-1:0]     tx_byte, tx_byte_n;
   logic [DATA_W-1:0] tx_shift, tx_shift_n;
   logic [7:0]        tx_cur;
   logic              tx_n, tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_LAST);

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt + CW'(1);
      tx_bit_n   = tx_bit;
      tx_byte_n  = tx_byte;
      tx_shift_n = tx_shift;
      tx_pop     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            tx_cnt_n = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_n = tx_mem[tx_rd_ptr[AW-1:0]];
               tx_byte_n  = '0;
               tx_state_n = S_START;
            end
         end
         S_START: begin
            if (tx_bit_end) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_n = '0;
               if (tx_bit == 3'd7) tx_state_n = HAS_PAR ? S_PAR : S_STOP;
               else                tx_bit_n   = tx_bit + 3'd1;
            end
         end
         S_PAR: begin
            if (tx_bit_end) begin
               tx_cnt_n   = '0;
               tx_state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_n = '0;
               if (tx_byte != BYTE_LAST) begin
                  tx_byte_n  = tx_byte + BW'(1);
                  tx_shift_n = tx_shift >> 8;
                  tx_state_n = S_START;
               end else begin
                  tx_state_n = S_IDLE;
               end
            end
         end
         default: tx_state_n = S_IDLE;
      endcase

      // The line level is registered from the next state so tx never glitches.
      tx_cur = tx_shift_n[7:0];
      case (tx_state_n)
         S_START: tx_n = 1'b0;
         S_DATA:  tx_n = tx_cur[tx_bit_n];
         S_PAR:   tx_n = (^tx_cur) ^ ODD_PAR;
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_byte  <= tx_byte_n;
         tx_shift <= tx_shift_n;
         tx       <= tx_n;
      end
   end

   assign tx_busy = !tx_empty || (tx_state != S_IDLE);

   // ---------------------------------------------------------------- RX FSM
   logic rx_meta, rx_s, rx_s_d, rx_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end
   assign rx_fall = rx_s_d && !rx_s;

   state_t            rx_state, rx_state_n;
   logic [CW-1:0]     rx_cnt, rx_cnt_n;
   logic [2:0]        rx_bit, rx_bit_n;
   logic [BW-1:0]     rx_idx, rx_idx_n;
   logic [7:0]        rx_byte, rx_byte_n;
   logic [DATA_W-1:0] rx_word, rx_word_n;
   logic              rx_bit_end, rx_push, par_set, frm_set;

   assign rx_bit_end = (rx_cnt == BIT_LAST);

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + CW'(1);
      rx_bit_n   = rx_bit;
      rx_idx_n   = rx_idx;
      rx_byte_n  = rx_byte;
      rx_word_n  = rx_word;
      rx_push    = 1'b0;
      par_set    = 1'b0;
      frm_set    = 1'b0;
      case (rx_state)
         S_IDLE: begin
            rx_cnt_n = '0;
            if (rx_fall) rx_state_n = S_START;
         end
         S_START: begin
            // Mid-start-bit check; a high line means the edge was noise.
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n = '0;
               if (rx_s) begin
                  rx_state_n = S_IDLE;
               end else begin
                  rx_bit_n   = '0;
                  rx_state_n = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_n  = '0;
               rx_byte_n = {rx_s, rx_byte[7:1]};
               if (rx_bit == 3'd7) rx_state_n = HAS_PAR ? S_PAR : S_STOP;
               else                rx_bit_n   = rx_bit + 3'd1;
            end
         end
         S_PAR: begin
            if (rx_bit_end) begin
               rx_cnt_n   = '0;
               par_set    = ((^rx_byte) ^ rx_s) != ODD_PAR;
               rx_state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_bit_end) begin
               rx_cnt_n   = '0;
               frm_set    = !rx_s;
               rx_word_n[{rx_idx, 3'b000} +: 8] = rx_byte;
               rx_state_n = S_IDLE;
               if (rx_idx == BYTE_LAST) begin
                  rx_push  = 1'b1;
                  rx_idx_n = '0;
               end else begin
                  rx_idx_n = rx_idx + BW'(1);
               end
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_idx   <= '0;
         rx_byte  <= '0;
         rx_word  <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_idx   <= rx_idx_n;
         rx_byte  <= rx_byte_n;
         rx_word  <= rx_word_n;
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0]     rx_wr_ptr, rx_rd_ptr;
   logic              rx_full, rx_pop, rx_accept, ovr_set;

   assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
   assign rx_full   = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                      (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
   assign rx_pop    = rd_en && !rx_empty;
   assign rx_accept = rx_push && (!rx_full || rx_pop);
   assign ovr_set   = rx_push && rx_full && !rx_pop;
   assign data_out  = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rx_accept) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_word_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
      end else begin
         if (rx_accept) rx_wr_ptr <= rx_wr_ptr + PW'(1);
         if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + PW'(1);
      end
   end

   // Sticky flags: a set event in the same cycle as clr_err wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (par_set)      parity_err <= 1'b1;
         else if (clr_err) parity_err <= 1'b0;
         if (frm_set)      frame_err  <= 1'b1;
         else if (clr_err) frame_err  <= 1'b0;
         if (ovr_set)      overrun    <= 1'b1;
         else if (clr_err) overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_interface_param.sv
// Self-checking bench: a 32-bit no-parity instance (tx framing, loopback, overrun,
// reset abort, random traffic) and an 8-bit even-parity instance (injected frames).
module tb_serial_interface_param;
   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Instance A: DATA_W=32, PARITY=0
   logic        reset_a, control_a, rd_en_a, rx_a, rx_drv_a, loop_a, clr_a;
   logic [31:0] data_in_a, data_out_a;
   logic        tx_a, tx_full_a, tx_busy_a, rx_empty_a, perr_a, ferr_a, ovr_a;
   assign rx_a = loop_a ? tx_a : rx_drv_a;

   serial_interface_param #(.DATA_W(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0)) u_dut32 (
      .clk(clk), .reset(reset_a), .data_in(data_in_a), .control(control_a), .rd_en(rd_en_a),
      .rx(rx_a), .tx(tx_a), .data_out(data_out_a), .tx_full(tx_full_a), .tx_busy(tx_busy_a),
      .rx_empty(rx_empty_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
      .clr_err(clr_a));

   // Instance B: DATA_W=8, PARITY=1 (even)
   logic       reset_b, control_b, rd_en_b, rx_b, clr_b;
   logic [7:0] data_in_b, data_out_b;
   logic       tx_b, tx_full_b, tx_busy_b, rx_empty_b, perr_b, ferr_b, ovr_b;

   serial_interface_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1)) u_dut8 (
      .clk(clk), .reset(reset_b), .data_in(data_in_b), .control(control_b), .rd_en(rd_en_b),
      .rx(rx_b), .tx(tx_b), .data_out(data_out_b), .tx_full(tx_full_b), .tx_busy(tx_busy_b),
      .rx_empty(rx_empty_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
      .clr_err(clr_b));

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic [7:0] exp_d;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_a(input logic [31:0] w);
      data_in_a = w;
      control_a = 1'b1;
      @(negedge clk);
      control_a = 1'b0;
   endtask

   task automatic pop_a();
      rd_en_a = 1'b1;
      @(negedge clk);
      rd_en_a = 1'b0;
   endtask

   // Line level of bit k of a 32-bit no-parity word: 4 frames of start, 8 data, stop.
   function automatic logic exp_tx_bit(input logic [31:0] w, input int k);
      int byt, pos;
      byt = k / 10;
      pos = k % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return w[byt*8 + pos - 1];
   endfunction

   task automatic wait_tx_start_a(input string tag);
      int waited = 0;
      while (tx_a !== 1'b0 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_start"}, 64'(tx_a), 64'd0);
   endtask

   // Samples all 40 bit cells mid-bit; el returns cycles elapsed since tx fell.
   task automatic check_tx_word_a(input logic [31:0] w, input string tag, output int el);
      el = 0;
      wait_tx_start_a(tag);
      for (int k = 0; k < 40; k++) begin
         while (el < 4*k + 2) begin
            @(negedge clk);
            el++;
         end
         check($sformatf("%s_bit%0d", tag, k), 64'(tx_a), 64'(exp_tx_bit(w, k)));
      end
   endtask

   task automatic wait_rx_a(input int budget, input string tag);
      int waited = 0;
      while (rx_empty_a && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_rx_arrived"}, 64'(rx_empty_a), 64'd0);
   endtask

   task automatic send_frame_b(input logic [7:0] d, input logic p, input logic s);
      logic [10:0] bits;
      bits = {s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_b = bits[i];
         repeat (CPB) @(negedge clk);
      end
      rx_b = 1'b1;
   endtask

   task automatic wait_rx_b(input string tag);
      int waited = 0;
      while (rx_empty_b && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_rx_arrived"}, 64'(rx_empty_b), 64'd0);
   endtask

   task automatic pop_b();
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[8];
      logic [31:0] words[6];
      logic [31:0] exp_q[$];
      logic [31:0] w;
      int          el, pushed, got, cyc;

      tbl[0] = '{d: 8'h07, p: 1'b1, s: 1'b1, exp_d: 8'h07, exp_perr: 1'b0, exp_ferr: 1'b0};
      tbl[1] = '{d: 8'h07, p: 1'b0, s: 1'b1, exp_d: 8'h07, exp_perr: 1'b1, exp_ferr: 1'b0};
      tbl[2] = '{d: 8'h00, p: 1'b0, s: 1'b1, exp_d: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
      tbl[3] = '{d: 8'hA5, p: 1'b0, s: 1'b1, exp_d: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
      tbl[4] = '{d: 8'hA5, p: 1'b1, s: 1'b1, exp_d: 8'hA5, exp_perr: 1'b1, exp_ferr: 1'b0};
      tbl[5] = '{d: 8'h80, p: 1'b1, s: 1'b0, exp_d: 8'h80, exp_perr: 1'b0, exp_ferr: 1'b1};
      tbl[6] = '{d: 8'hFF, p: 1'b0, s: 1'b1, exp_d: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b0};
      tbl[7] = '{d: 8'h01, p: 1'b0, s: 1'b0, exp_d: 8'h01, exp_perr: 1'b1, exp_ferr: 1'b1};
      words = '{32'h11111111, 32'h22222222, 32'h33333333,
                32'h44444444, 32'h55555555, 32'h66666666};

      reset_a = 1'b0; control_a = 1'b0; rd_en_a = 1'b0; rx_drv_a = 1'b1; loop_a = 1'b0;
      clr_a = 1'b0; data_in_a = '0;
      reset_b = 1'b0; control_b = 1'b0; rd_en_b = 1'b0; rx_b = 1'b1; clr_b = 1'b0;
      data_in_b = '0;

      // ---- Reset values
      tick(2);
      check("rst_tx", 64'(tx_a), 64'd1);
      check("rst_rx_empty", 64'(rx_empty_a), 64'd1);
      reset_a = 1'b1;
      reset_b = 1'b1;
      tick(3);
      check("idle_tx", 64'(tx_a), 64'd1);
      check("idle_tx_full", 64'(tx_full_a), 64'd0);
      check("idle_tx_busy", 64'(tx_busy_a), 64'd0);
      check("idle_rx_empty", 64'(rx_empty_a), 64'd1);
      check("idle_data_out", 64'(data_out_a), 64'd0);
      check("idle_flags", 64'({perr_a, ferr_a, ovr_a}), 64'd0);
      check("idle_b_tx", 64'(tx_b), 64'd1);
      check("idle_b_rx_empty", 64'(rx_empty_b), 64'd1);

      // ---- Test 1: all-ones word framing and busy duration
      push_a(32'hFFFFFFFF);
      check_tx_word_a(32'hFFFFFFFF, "t1", el);
      while (tx_busy_a && el < 300) begin
         @(negedge clk);
         el++;
      end
      check("t1_busy_fall_cycles", 64'(el), 64'd160);

      // ---- Test 2: loopback single word
      loop_a = 1'b1;
      tick(5);
      push_a(32'h12345678);
      check_tx_word_a(32'h12345678, "t2", el);
      while (rx_empty_a && el < 220) begin
         @(negedge clk);
         el++;
      end
      check("t2_rx_after_last_stop", 64'(el >= 157 && el <= 168), 64'd1);
      check("t2_data_out", 64'(data_out_a), 64'h12345678);
      check("t2_flags", 64'({perr_a, ferr_a, ovr_a}), 64'd0);
      pop_a();
      check("t2_rx_empty_after_pop", 64'(rx_empty_a), 64'd1);
      check("t2_data_out_after_pop", 64'(data_out_a), 64'd0);

      // ---- Test 3: TX FIFO full, RX overrun, 6th push dropped
      tick(10);
      for (int i = 0; i < 6; i++) begin
         if (i == 4) check("t3_not_full_before_5th", 64'(tx_full_a), 64'd0);
         if (i == 5) check("t3_full_before_6th", 64'(tx_full_a), 64'd1);
         data_in_a = words[i];
         control_a = 1'b1;
         @(negedge clk);
      end
      control_a = 1'b0;
      cyc = 0;
      while (tx_busy_a && cyc < 1200) begin
         @(negedge clk);
         cyc++;
      end
      check("t3_tx_drained", 64'(tx_busy_a), 64'd0);
      tick(30);
      check("t3_overrun", 64'(ovr_a), 64'd1);
      check("t3_head_is_word1", 64'(data_out_a), 64'(words[0]));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_pop%0d", i), 64'(data_out_a), 64'(words[i]));
         pop_a();
      end
      check("t3_rx_empty", 64'(rx_empty_a), 64'd1);
      check("t3_overrun_sticky", 64'(ovr_a), 64'd1);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("t3_overrun_cleared", 64'(ovr_a), 64'd0);

      // ---- Random loopback traffic against a queue model
      pushed = 0;
      got = 0;
      cyc = 0;
      while (got < 10 && cyc < 4000) begin
         control_a = 1'b0;
         rd_en_a = 1'b0;
         if (pushed < 10 && !tx_full_a && ($urandom % 4) == 0) begin
            w = $urandom;
            data_in_a = w;
            control_a = 1'b1;
            exp_q.push_back(w);
            pushed++;
         end
         if (!rx_empty_a && ($urandom % 2) == 0) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected_word", 64'(data_out_a), 64'd0);
               n_err += (data_out_a == 0) ? 1 : 0;
            end else begin
               check($sformatf("rand_word%0d", got), 64'(data_out_a), 64'(exp_q.pop_front()));
            end
            rd_en_a = 1'b1;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      control_a = 1'b0;
      rd_en_a = 1'b0;
      check("rand_all_received", 64'(got), 64'd10);
      check("rand_no_flags", 64'({perr_a, ferr_a, ovr_a}), 64'd0);
      tick(5);
      check("rand_rx_empty", 64'(rx_empty_a), 64'd1);

      // ---- Test 6: reset in the middle of the second byte
      tick(10);
      push_a(32'hAABBCCDD);
      push_a(32'h01020304);
      wait_tx_start_a("t6");
      tick(60);
      reset_a = 1'b0;
      #1;
      check("t6_tx_high_at_reset", 64'(tx_a), 64'd1);
      check("t6_busy_low_at_reset", 64'(tx_busy_a), 64'd0);
      check("t6_full_low_at_reset", 64'(tx_full_a), 64'd0);
      @(negedge clk);
      check("t6_tx_high_held", 64'(tx_a), 64'd1);
      reset_a = 1'b1;
      tick(3);
      check("t6_rx_partial_dropped", 64'(rx_empty_a), 64'd1);
      check("t6_busy_after_release", 64'(tx_busy_a), 64'd0);
      push_a(32'h0F0F0F0F);
      check_tx_word_a(32'h0F0F0F0F, "t6_new", el);
      wait_rx_a(30, "t6_new");
      check("t6_new_data", 64'(data_out_a), 64'h0F0F0F0F);
      pop_a();
      check("t6_single_word", 64'(rx_empty_a), 64'd1);
      check("t6_no_flags", 64'({perr_a, ferr_a, ovr_a}), 64'd0);

      // ---- Table: injected 8-bit frames with chosen parity/stop bits
      for (int i = 0; i < 8; i++) begin
         clr_b = 1'b1;
         @(negedge clk);
         clr_b = 1'b0;
         tick(4);
         send_frame_b(tbl[i].d, tbl[i].p, tbl[i].s);
         wait_rx_b($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_data", i), 64'(data_out_b), 64'(tbl[i].exp_d));
         check($sformatf("tbl%0d_parity_err", i), 64'(perr_b), 64'(tbl[i].exp_perr));
         check($sformatf("tbl%0d_frame_err", i), 64'(ferr_b), 64'(tbl[i].exp_ferr));
         pop_b();
         check($sformatf("tbl%0d_rx_empty", i), 64'(rx_empty_b), 64'd1);
         tick(8);
      end

      // ---- Test 4: parity error stickiness and clr_err
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      send_frame_b(8'h07, 1'b0, 1'b1);
      wait_rx_b("t4_bad");
      check("t4_parity_err", 64'(perr_b), 64'd1);
      check("t4_data", 64'(data_out_b), 64'h07);
      pop_b();
      tick(4);
      send_frame_b(8'h03, 1'b0, 1'b1);
      wait_rx_b("t4_good");
      check("t4_parity_err_sticky", 64'(perr_b), 64'd1);
      check("t4_good_data", 64'(data_out_b), 64'h03);
      pop_b();
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      check("t4_parity_err_cleared", 64'(perr_b), 64'd0);
      check("t4_frame_err_clear", 64'(ferr_b), 64'd0);

      // ---- Test 5: one-cycle glitch on idle rx is rejected
      tick(8);
      rx_b = 1'b0;
      @(negedge clk);
      rx_b = 1'b1;
      tick(40);
      check("t5_glitch_no_byte", 64'(rx_empty_b), 64'd1);
      check("t5_glitch_no_flags", 64'({perr_b, ferr_b}), 64'd0);
      send_frame_b(8'h5A, 1'b0, 1'b1);
      wait_rx_b("t5_after_glitch");
      check("t5_after_glitch_data", 64'(data_out_b), 64'h5A);
      check("t5_after_glitch_flags", 64'({perr_b, ferr_b, ovr_b}), 64'd0);
      pop_b();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_interface_param.md
Name: serial_interface_param

Overview:
- Parametrised UART-style serial interface: the next generation of the team's fixed 32-bit serial interface.
- Accepts DATA_W-bit words from the core into a TX FIFO and serialises each word as DATA_W/8 byte frames, LSB byte first.
- Deserialises incoming frames on rx, reassembles them into words and queues those words in an RX FIFO for the core.
- Adds configurable width, FIFO depth, baud divisor and parity mode, plus error and status flags. Used standalone or in tx->rx loopback.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8, range 8..64.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 4.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; must be a power of 2 and at least 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; when enabled, one parity bit follows data bit 7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  word to transmit.
- control  in  1  write strobe; pushes data_in into the TX FIFO when high for one cycle and tx_full=0.
- rd_en  in  1  pops the RX FIFO head when high and rx_empty=0.
- rx  in  1  serial input; idle high; asynchronous to clk.
- tx  out  1  serial output; idle high.
- data_out  out  DATA_W  RX FIFO head (first-word fall-through).
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO non-empty or a frame in flight.
- rx_empty  out  1  RX FIFO empty.
- parity_err  out  1  sticky; set by a parity mismatch on any received byte.
- frame_err  out  1  sticky; set when a stop bit samples 0.
- overrun  out  1  sticky; set when a completed word arrives while the RX FIFO is full.
- clr_err  in  1  clears all sticky flags next cycle; if a set event coincides, set wins.

Behaviour:
- Reset values: tx=1, data_out=0, tx_full=0, tx_busy=0, rx_empty=1, all error flags 0. Both FIFOs empty, both FSMs in IDLE, byte indices 0.
- Reset is asserted asynchronously and released synchronously through a 2-flop synchroniser.
- Reset mid-frame aborts the frame immediately: tx goes to 1 and any partial RX word is discarded.
- TX FIFO:
  - control with tx_full=0 writes data_in. control with tx_full=1 is ignored and the word is dropped.
  - A push and a pop in the same cycle are both honoured.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START when the FIFO is non-empty. The head word is loaded into a shift register and popped in the same cycle; byte index = 0.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - START drives tx=0. DATA sends 8 bits LSB first. PAR is sent only if PARITY != 0. STOP drives tx=1.
  - After STOP: if byte index < DATA_W/8-1, increment it and go to START with no idle gap. Otherwise go to IDLE, and on to the next word if one is queued (one idle clk cycle permitted).
- Word frame time: DATA_W/8 * (10 + (PARITY != 0)) * CLKS_PER_BIT cycles.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START re-samples at CLKS_PER_BIT/2. If the line is 1, the edge was a glitch: return to IDLE.
  - Later bits are sampled every CLKS_PER_BIT cycles from that midpoint.
  - Each byte is placed in byte lane [index*8 +: 8] of the assembly register.
  - A parity mismatch sets parity_err; the byte is still kept. A stop bit of 0 sets frame_err; the byte is still kept.
  - After the last byte's stop bit, the word is pushed into the RX FIFO and the byte index returns to 0.
  - If the RX FIFO is full at that push, the word is dropped, overrun is set, and the FIFO contents are unchanged.
- RX FIFO:
  - rd_en with rx_empty=1 is ignored.
  - data_out shows the new head on the cycle after a pop.
  - A simultaneous push and pop on a full FIFO succeeds; no overrun.
- Pointers use log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the remaining bits are equal; wrap-around is natural.

Test Plan:
1. Reset held low for 2 cycles, then released, with DATA_W=32, CLKS_PER_BIT=4, PARITY=0 -> tx=1, rx_empty=1, all flags 0. One control pulse with data_in=32'hFFFFFFFF -> 4 frames; each frame is one 0 then nine 1s, 4 cycles per bit; tx_busy falls 160 cycles after the frame starts.
2. Loopback (rx tied to tx), data_in=32'h12345678 -> rx_empty falls after the last stop bit is sampled; data_out=32'h12345678; rd_en -> rx_empty=1.
3. Push 5 words with FIFO_DEPTH=4 while TX is idle -> first word starts transmitting, remaining 4 are queued and tx_full=1. In loopback with no rd_en, the 5th word sets overrun=1, and data_out still holds word 1.
4. PARITY=1, DATA_W=8, inject byte 8'h07 with parity bit 0 -> parity_err=1 and data_out=8'h07. clr_err -> parity_err=0 next cycle.
5. Stop bit driven 0 on rx -> frame_err=1. A 1-cycle low glitch on idle rx -> no byte received, FSM returns to IDLE.
6. Assert reset in the middle of the second TX byte -> tx=1 immediately, TX FIFO empty, tx_busy=0. A new word after release transmits cleanly.
